// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall scheduler: merges IF/ID/EX stall requests into the 6-bit stall
// vector, sequences multi-cycle EX ops and keeps a saturating stall-cycle counter.
module pipe_stall_ctrl #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              ex_mc_req,
   input  logic [CNT_W-1:0]  ex_mc_cycles,
   input  logic              flush,
   output logic [5:0]        stall,
   output logic [CNT_W-1:0]  ex_mc_cnt,
   output logic              ex_mc_done,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   localparam logic RstEnable = 1'b1;

   localparam logic [5:0] StallEx   = 6'b001111;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallIf   = 6'b000011;
   localparam logic [5:0] StallNone = 6'b000000;

   localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CntTwo  = CNT_W'(2);
   localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [PERF_W-1:0] perf_q, perf_d;

   logic is_idle;
   logic is_busy;
   logic mc_start;
   logic mc_single;
   logic mc_last;
   logic ex_stall;

   always_comb begin
      is_idle   = (state_q == IDLE);
      is_busy   = (state_q == BUSY);
      mc_start  = is_idle && ex_mc_req && (ex_mc_cycles >= CntTwo);
      mc_single = is_idle && ex_mc_req && (ex_mc_cycles < CntTwo);
      mc_last   = is_busy && (cnt_q == len_q - CntOne);
      ex_stall  = mc_start || (is_busy && !mc_last);
   end

   // NOTE: every signal written here gets a default first so no path leaves one
   // unassigned; a missed branch in a combinational block would infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      stall      = StallNone;
      ex_mc_done = 1'b0;
      ex_mc_cnt  = is_busy ? cnt_q : '0;

      // EX stall masks the ID/IF requests; they reappear in the done cycle.
      if (ex_stall) begin
         stall = StallEx;
      end else if (stallreq_id) begin
         stall = StallId;
      end else if (stallreq_if) begin
         stall = StallIf;
      end

      ex_mc_done = mc_single || mc_last;

      unique case (state_q)
         IDLE: begin
            if (mc_start) begin
               len_d   = ex_mc_cycles;
               cnt_d   = CntOne;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mc_last) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // A flush aborts the op outright, including on its final cycle.
      if (flush) begin
         stall      = StallNone;
         ex_mc_done = 1'b0;
         cnt_d      = '0;
         state_d    = IDLE;
      end

      if (rst == RstEnable) begin
         stall      = StallNone;
         ex_mc_done = 1'b0;
         ex_mc_cnt  = '0;
      end

      perf_d = perf_q;
      if ((stall != StallNone) && (perf_q != {PERF_W{1'b1}})) begin
         perf_d = perf_q + PerfOne;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         perf_q  <= perf_d;
      end
   end

   assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: table-driven vectors through a
// scoreboard queue, plus hand-written multi-cycle, flush, reset and saturation runs.
module tb_pipe_stall_ctrl;

   localparam int CNT_W  = 6;
   localparam int PERF_W = 6;

   typedef struct {
      logic             rst;
      logic             sif;
      logic             sid;
      logic             req;
      logic [CNT_W-1:0] cyc;
      logic             flush;
      logic [5:0]       exp_stall;
      logic [CNT_W-1:0] exp_cnt;
      logic             exp_done;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              stallreq_if;
   logic              stallreq_id;
   logic              ex_mc_req;
   logic [CNT_W-1:0]  ex_mc_cycles;
   logic              flush;
   logic [5:0]        stall;
   logic [CNT_W-1:0]  ex_mc_cnt;
   logic              ex_mc_done;
   logic [PERF_W-1:0] perf_stall_cnt;

   int errors = 0;
   int checks = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_if    (stallreq_if),
      .stallreq_id    (stallreq_id),
      .ex_mc_req      (ex_mc_req),
      .ex_mc_cycles   (ex_mc_cycles),
      .flush          (flush),
      .stall          (stall),
      .ex_mc_cnt      (ex_mc_cnt),
      .ex_mc_done     (ex_mc_done),
      .perf_stall_cnt (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic sif, input logic sid, input logic req,
                               input int cyc, input logic fl, input logic [5:0] es,
                               input int ec, input logic ed);
      vec_t v;
      v.rst = r; v.sif = sif; v.sid = sid; v.req = req; v.cyc = CNT_W'(cyc);
      v.flush = fl; v.exp_stall = es; v.exp_cnt = CNT_W'(ec); v.exp_done = ed;
      return v;
   endfunction

   // Drive one cycle, record its expectation, compare at the following negedge.
   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      rst          = v.rst;
      stallreq_if  = v.sif;
      stallreq_id  = v.sid;
      ex_mc_req    = v.req;
      ex_mc_cycles = v.cyc;
      flush        = v.flush;
      exp_q.push_back(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, " stall"}, 32'(stall), 32'(e.exp_stall));
         check({tag, " cnt"},   32'(ex_mc_cnt), 32'(e.exp_cnt));
         check({tag, " done"},  32'(ex_mc_done), 32'(e.exp_done));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0;
      ex_mc_req = 1'b0; ex_mc_cycles = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset forces outputs even with live requests present.
      apply("rst0", mk(1, 1, 1, 1, 5, 0, 6'b000000, 0, 0));
      apply("rst1", mk(1, 1, 1, 1, 1, 1, 6'b000000, 0, 0));
      check("perf after rst", 32'(perf_stall_cnt), 0);
      for (int i = 0; i < 10; i++) apply($sformatf("idle%0d", i), mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      check("perf after idle", 32'(perf_stall_cnt), 0);

      // Basic vectors: priority encoding, single-cycle ops, back-to-back madd, flush in IDLE.
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 6'b000111, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 6'b000111, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 6'b000111, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 6'b000011, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 6'b000000, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 6'b000000, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 6'b000111, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 6'b001111, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 6'b000000, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 6'b001111, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2, 0, 6'b000000, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 5, 1, 6'b000000, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);
      check("perf after table", 32'(perf_stall_cnt), 7);

      // Divide of 34 cycles with a load-use request held throughout.
      for (int i = 0; i < 34; i++)
         apply($sformatf("div%0d", i),
               mk(0, 0, 1, 1, 34, 0, (i < 33) ? 6'b001111 : 6'b000111, i, i == 33));
      apply("div_after", mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      check("perf after div", 32'(perf_stall_cnt), 41);

      // Length-10 op flushed in its 5th cycle.
      for (int i = 0; i < 4; i++) apply($sformatf("fl%0d", i), mk(0, 0, 0, 1, 10, 0, 6'b001111, i, 0));
      apply("fl_cyc5", mk(0, 0, 1, 1, 10, 1, 6'b000000, 4, 0));
      apply("fl_next", mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      check("perf after flush", 32'(perf_stall_cnt), 45);

      // Flush coinciding with the final BUSY cycle suppresses the done pulse.
      apply("lf0", mk(0, 0, 0, 1, 3, 0, 6'b001111, 0, 0));
      apply("lf1", mk(0, 0, 0, 1, 3, 0, 6'b001111, 1, 0));
      apply("lf2", mk(0, 0, 0, 1, 3, 1, 6'b000000, 2, 0));
      apply("lf3", mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      check("perf after last flush", 32'(perf_stall_cnt), 47);

      // Length-10 op aborted by reset (with flush) in its 5th cycle.
      for (int i = 0; i < 4; i++) apply($sformatf("rs%0d", i), mk(0, 0, 0, 1, 10, 0, 6'b001111, i, 0));
      apply("rs_cyc5", mk(1, 1, 1, 1, 10, 1, 6'b000000, 0, 0));
      apply("rs_next", mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      check("perf after mid rst", 32'(perf_stall_cnt), 0);

      // Saturation of the stall counter.
      for (int i = 0; i < 70; i++) apply($sformatf("sat%0d", i), mk(0, 0, 1, 0, 0, 0, 6'b000111, 0, 0));
      check("perf saturated", 32'(perf_stall_cnt), 63);

      check("scoreboard drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
